avl_bus_arb: RTL

//  Request arbiter and read-response router for the N-to-1 Avalon bus stage.
//  - Grants one of MASTER_NUM masters access to a single slave port.
//  - Records the master ID of every accepted read in an in-order select FIFO, so

---
 rtl/avl_bus_type.sv | 31 +++
 rtl/avl_bus_sel_fifo.sv | 69 ++++++
 rtl/avl_bus_arb.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/avl_bus_type.sv
// Shared types and helpers for the Avalon N-to-1 bus stage.
//
// Contents:
//   arb_method_e   - arbitration policy selector (round-robin / fixed priority)
//   arb_state_e    - arbiter FSM states
//   onehot_to_idx  - converts a one-hot vector (up to 16 bits) to its bit index
package avl_bus_type;

  typedef enum logic {
    ARB_RR    = 1'b0,
    ARB_FIXED = 1'b1
  } arb_method_e;

  typedef enum logic {
    ARB_IDLE,
    ARB_GRANT
  } arb_state_e;

  // Encodes each index bit as the OR of all one-hot positions whose index
  // has that bit set; an all-zero input yields 0.
  function automatic int onehot_to_idx(input logic [15:0] onehot);
    int idx;
    idx = 0;
    if (|(onehot & 16'hAAAA)) idx += 1;
    if (|(onehot & 16'hCCCC)) idx += 2;
    if (|(onehot & 16'hF0F0)) idx += 4;
    if (|(onehot & 16'hFF00)) idx += 8;
    return idx;
  endfunction

endpackage

// File: rtl/avl_bus_sel_fifo.sv
// In-order select FIFO holding the master ID of every accepted read.
//
// Parameters:
//   WIDTH  width of one stored ID
//   DEPTH  number of entries (power of 2, >= 2)
// Ports:
//   clk        in   bus clock
//   rest       in   asynchronous active-low reset (empties the FIFO)
//   push       in   store push_data (accepted at full only together with pop)
//   push_data  in   ID to store
//   pop        in   discard the head entry (ignored when empty)
//   full       out  FIFO holds DEPTH entries
//   empty      out  FIFO holds no entries
//   head       out  oldest stored ID (valid when !empty)
module avl_bus_sel_fifo #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rest,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  // A push at full is only safe when the head leaves in the same cycle.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rest) begin
    if (!rest) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; entries are only read after being written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/avl_bus_arb.sv
// Request arbiter and read-response router for the N-to-1 Avalon bus stage.
// Grants one master at a time to the slave port and remembers the issuer of
// every accepted read so readdatavalid beats are steered back in order.
//
// Parameters:
//   MASTER_NUM      number of requesters (1,2,4,8,16)
//   ARB_METHOD      0: round-robin, 1: fixed priority (index 0 highest)
//   SEL_FIFO_DEPTH  max outstanding reads (power of 2, >= 2)
// Ports:
//   clk                in   bus clock
//   rest               in   asynchronous active-low reset
//   req                in   per-master pending command
//   req_read           in   per-master: pending command is a read
//   slv_waitrequest    in   slave stalls the granted command
//   slv_readdatavalid  in   slave returns one read beat
//   grant              out  registered one-hot grant
//   grant_valid        out  |grant
//   grant_id           out  index of the granted master
//   rsp_valid          out  one-hot readdatavalid route (combinational)
//   sel_fifo_full      out  select FIFO is full
//   rsp_err            out  sticky: readdatavalid arrived with nothing queued
//   grant_cnt          out  per-master saturating accept counters, present
//                           only when AVL_BUS_ARB_PERF_CNT_EN is defined
module avl_bus_arb
  import avl_bus_type::*;
#(
  parameter  int MASTER_NUM     = 4,
  parameter  int ARB_METHOD     = 0,
  parameter  int SEL_FIFO_DEPTH = 8,
  localparam int ID_W           = (MASTER_NUM > 1) ? $clog2(MASTER_NUM) : 1
) (
  input  logic                  clk,
  input  logic                  rest,
  input  logic [MASTER_NUM-1:0] req,
  input  logic [MASTER_NUM-1:0] req_read,
  input  logic                  slv_waitrequest,
  input  logic                  slv_readdatavalid,
  output logic [MASTER_NUM-1:0] grant,
  output logic                  grant_valid,
  output logic [ID_W-1:0]       grant_id,
  output logic [MASTER_NUM-1:0] rsp_valid,
  output logic                  sel_fifo_full,
  output logic                  rsp_err
`ifdef AVL_BUS_ARB_PERF_CNT_EN
  ,
  output logic [MASTER_NUM-1:0][31:0] grant_cnt
`endif
);

  localparam arb_method_e METHOD = arb_method_e'(ARB_METHOD[0]);

  arb_state_e              state;
  arb_state_e              state_nxt;
  logic [MASTER_NUM-1:0]   grant_nxt;
  logic [ID_W-1:0]         grant_id_nxt;
  logic [ID_W-1:0]         rr_ptr;
  logic [ID_W-1:0]         rr_ptr_nxt;
  logic [MASTER_NUM-1:0]   winner;
  logic [2*MASTER_NUM-1:0] req_dbl;
  logic [2*MASTER_NUM-1:0] win_dbl;
  logic [MASTER_NUM-1:0]   rot;
  logic [MASTER_NUM-1:0]   rot_low;
  logic                    accept;
  logic                    push;
  logic                    pop;
  logic                    fifo_empty;
  logic [ID_W-1:0]         head;

  assign grant_valid = |grant;
  assign accept      = grant_valid && !slv_waitrequest;
  assign push        = accept && req_read[grant_id];
  assign pop         = slv_readdatavalid && !fifo_empty;

  // Round-robin: rotate req so the pointer lands at bit 0, isolate the lowest
  // set bit (x & -x), then rotate back. Fixed priority skips the rotation.
  always_comb begin
    req_dbl = {req, req} >> rr_ptr;
    rot     = req_dbl[MASTER_NUM-1:0];
    rot_low = rot & (-rot);
    win_dbl = {rot_low, rot_low} << rr_ptr;
    if (METHOD == ARB_FIXED) winner = req & (-req);
    else                     winner = win_dbl[2*MASTER_NUM-1:MASTER_NUM];
  end

  // Next-state logic. A grant always goes back through IDLE after acceptance,
  // which gives the mandatory one-cycle bubble between grants. The grant is
  // held through waitrequest regardless of what the winner's req does.
  always_comb begin
    state_nxt    = state;
    grant_nxt    = grant;
    grant_id_nxt = grant_id;
    rr_ptr_nxt   = rr_ptr;
    case (state)
      ARB_IDLE: begin
        if (|req && !sel_fifo_full) begin
          grant_nxt    = winner;
          grant_id_nxt = ID_W'(onehot_to_idx(16'(winner)));
          state_nxt    = ARB_GRANT;
        end
      end
      ARB_GRANT: begin
        if (accept) begin
          grant_nxt = '0;
          state_nxt = ARB_IDLE;
          if (METHOD == ARB_RR) begin
            rr_ptr_nxt = (grant_id == ID_W'(MASTER_NUM - 1)) ? '0 : grant_id + ID_W'(1);
          end
        end
      end
      default: begin
        grant_nxt = '0;
        state_nxt = ARB_IDLE;
      end
    endcase
  end

  // Arbiter state register.
  always_ff @(posedge clk or negedge rest) begin
    if (!rest) begin
      state    <= ARB_IDLE;
      grant    <= '0;
      grant_id <= '0;
      rr_ptr   <= '0;
    end else begin
      state    <= state_nxt;
      grant    <= grant_nxt;
      grant_id <= grant_id_nxt;
      rr_ptr   <= rr_ptr_nxt;
    end
  end

  // A beat with nothing queued has no owner; flag it until the next reset.
  always_ff @(posedge clk or negedge rest) begin
    if (!rest)                                 rsp_err <= 1'b0;
    else if (slv_readdatavalid && fifo_empty)  rsp_err <= 1'b1;
  end

  // Response route comes straight from the FIFO head in the beat's own cycle.
  always_comb begin
    rsp_valid = '0;
    if (pop) rsp_valid = MASTER_NUM'(1) << head;
  end

  avl_bus_sel_fifo #(
    .WIDTH (ID_W),
    .DEPTH (SEL_FIFO_DEPTH)
  ) u_sel_fifo (
    .clk       (clk),
    .rest      (rest),
    .push      (push),
    .push_data (grant_id),
    .pop       (pop),
    .full      (sel_fifo_full),
    .empty     (fifo_empty),
    .head      (head)
  );

`ifdef AVL_BUS_ARB_PERF_CNT_EN
  // One saturating accept counter per master.
  for (genvar m = 0; m < MASTER_NUM; m++) begin : g_cnt
    logic [31:0] cnt;
    always_ff @(posedge clk or negedge rest) begin
      if (!rest) begin
        cnt <= '0;
      end else if (accept && (grant_id == ID_W'(m)) && (cnt != 32'hFFFF_FFFF)) begin
        cnt <= cnt + 32'd1;
      end
    end
    assign grant_cnt[m] = cnt;
  end
`endif

endmodule
